// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store sequencer between the MEM stage and a single-port
// data SRAM (active-low byte write enables).
//
// Optional build macro: LSU_MISALIGN_SPLIT_EN
//   defined   - halfword/word accesses crossing a word boundary are split into
//               two aligned SRAM accesses (ACC1/WAIT1 present)
//   undefined - odd-aligned halfwords and non-word-aligned words respond with
//               resp_err and never touch the SRAM
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | ready for a request; decodes funct3/alignment on acceptance
// ACC0  | first SRAM access cycle at word W (write or read launch)
// WAIT0 | read latency for the first access; captures w0 on its last cycle
// ACC1  | second access at W+1 for word-crossing requests (split build only)
// WAIT1 | read latency for the second access; captures w1 (split build only)
// RESP  | one-cycle response pulse
module lsu_mem_ctrl #(
  parameter int ADDR_W  = 14,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_cs,
  output logic              mem_oe,
  output logic [3:0]        mem_web,
  output logic [ADDR_W-1:0] mem_a,
  output logic [31:0]       mem_di,
  input  logic [31:0]       mem_do
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ACC0  = 3'd1,
    S_WAIT0 = 3'd2,
    S_ACC1  = 3'd3,
    S_WAIT1 = 3'd4,
    S_RESP  = 3'd5
  } state_t;

  // Latency counter preload: WAIT lasts MEM_LAT cycles, data captured when it hits 0.
  localparam logic [1:0] LAT_M1 = 2'(MEM_LAT - 1);

  state_t             state_q, state_d;
  logic               write_q, write_d;
  logic [2:0]         funct3_q, funct3_d;
  logic [1:0]         k_q, k_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [ADDR_W-1:0]  mem_a_q, mem_a_d;
  logic [31:0]        w0_q, w0_d;
  logic [31:0]        w1_q, w1_d;
  logic               err_q, err_d;
  logic               split_q, split_d;
  logic [1:0]         cnt_q, cnt_d;

  // Upper byte-address bits beyond the SRAM are intentionally ignored.
  logic               unused_addr;
  assign unused_addr = ^req_addr[31:ADDR_W+2];

  logic [1:0]  req_k;
  logic        f3_bad;
  logic        mis_bad;
  logic        need_split;
  logic [3:0]  be0, be1;
  logic [31:0] di0, di1;
  logic [63:0] ld_cat;
  logic [31:0] ld_r;
  logic [31:0] ld_ext;

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  // Request decode: illegal funct3, unsupported misalignment, word crossing.
  always_comb begin
    req_k      = req_addr[1:0];
    f3_bad     = req_write ? (req_funct3 > 3'd2)
                           : ((req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11));
    need_split = ((req_funct3[1:0] == 2'b01) && (req_k == 2'd3)) ||
                 ((req_funct3[1:0] == 2'b10) && (req_k != 2'd0));
`ifdef LSU_MISALIGN_SPLIT_EN
    mis_bad    = 1'b0;
`else
    mis_bad    = ((req_funct3[1:0] == 2'b01) && req_k[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (req_k != 2'd0));
`endif
  end

  // Store lane enables and shifted write data for both access halves.
  always_comb begin
    case (funct3_q[1:0])
      2'b00:   be0 = 4'(4'b0001 << k_q);
      2'b01:   be0 = 4'(4'b0011 << k_q);
      default: be0 = 4'(4'b1111 << k_q);
    endcase
    di0 = (wdata_q << {k_q, 3'b000}) & lane_mask(be0);
    // Second half covers bytes 0..k+size-5: one byte for SH, k bytes for SW.
    if (funct3_q[1:0] == 2'b01) be1 = 4'b0001;
    else                        be1 = 4'((4'b0001 << k_q) - 4'd1);
    di1 = (wdata_q >> (6'd32 - {1'b0, k_q, 3'b000})) & lane_mask(be1);
  end

  // Load alignment and sign/zero extension.
  always_comb begin
    ld_cat = {w1_q, w0_q} >> {k_q, 3'b000};
    ld_r   = ld_cat[31:0];
    case (funct3_q[1:0])
      2'b00:   ld_ext = funct3_q[2] ? {24'd0, ld_r[7:0]}  : {{24{ld_r[7]}}, ld_r[7:0]};
      2'b01:   ld_ext = funct3_q[2] ? {16'd0, ld_r[15:0]} : {{16{ld_r[15]}}, ld_r[15:0]};
      default: ld_ext = ld_r;
    endcase
  end

  // Next-state and output logic.
  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    funct3_d   = funct3_q;
    k_d        = k_q;
    wdata_d    = wdata_q;
    mem_a_d    = mem_a_q;
    w0_d       = w0_q;
    w1_d       = w1_q;
    err_d      = err_q;
    split_d    = split_q;
    cnt_d      = cnt_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = 32'd0;
    resp_err   = 1'b0;
    mem_cs     = 1'b0;
    mem_oe     = 1'b0;
    mem_web    = 4'hF;
    mem_di     = 32'd0;

    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          write_d  = req_write;
          funct3_d = req_funct3;
          k_d      = req_k;
          wdata_d  = req_wdata;
          w0_d     = 32'd0;
          w1_d     = 32'd0;
          if (f3_bad || mis_bad) begin
            err_d   = 1'b1;
            split_d = 1'b0;
            state_d = S_RESP;
          end else begin
            err_d   = 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
            split_d = need_split;
`else
            split_d = 1'b0;
`endif
            mem_a_d = req_addr[ADDR_W+1:2];
            state_d = S_ACC0;
          end
        end
      end

      S_ACC0: begin
        mem_cs = 1'b1;
        if (write_q) begin
          mem_web = ~be0;
          mem_di  = di0;
          if (split_q) begin
            mem_a_d = mem_a_q + ADDR_W'(1);
            state_d = S_ACC1;
          end else begin
            state_d = S_RESP;
          end
        end else begin
          mem_oe  = 1'b1;
          cnt_d   = LAT_M1;
          state_d = S_WAIT0;
        end
      end

      S_WAIT0: begin
        mem_oe = 1'b1;
        if (cnt_q == 2'd0) begin
          w0_d = mem_do;
          if (split_q) begin
            mem_a_d = mem_a_q + ADDR_W'(1);
            state_d = S_ACC1;
          end else begin
            state_d = S_RESP;
          end
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end

`ifdef LSU_MISALIGN_SPLIT_EN
      S_ACC1: begin
        mem_cs = 1'b1;
        if (write_q) begin
          mem_web = ~be1;
          mem_di  = di1;
          state_d = S_RESP;
        end else begin
          mem_oe  = 1'b1;
          cnt_d   = LAT_M1;
          state_d = S_WAIT1;
        end
      end

      S_WAIT1: begin
        mem_oe = 1'b1;
        if (cnt_q == 2'd0) begin
          w1_d    = mem_do;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
`endif

      S_RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        if (!err_q && !write_q) resp_rdata = ld_ext;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign mem_a = mem_a_q;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      write_q  <= 1'b0;
      funct3_q <= 3'd0;
      k_q      <= 2'd0;
      wdata_q  <= 32'd0;
      mem_a_q  <= '0;
      w0_q     <= 32'd0;
      w1_q     <= 32'd0;
      err_q    <= 1'b0;
      split_q  <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      funct3_q <= funct3_d;
      k_q      <= k_d;
      wdata_q  <= wdata_d;
      mem_a_q  <= mem_a_d;
      w0_q     <= w0_d;
      w1_q     <= w1_d;
      err_q    <= err_d;
      split_q  <= split_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a behavioural SRAM of latency 2.
module tb_lsu_mem_ctrl;
  localparam int AW  = 14;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_write;
  logic [2:0]    req_funct3;
  logic [31:0]   req_addr, req_wdata;
  logic          resp_valid, resp_err;
  logic [31:0]   resp_rdata;
  logic          mem_cs, mem_oe;
  logic [3:0]    mem_web;
  logic [AW-1:0] mem_a;
  logic [31:0]   mem_di, mem_do;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.ADDR_W(AW), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_cs(mem_cs), .mem_oe(mem_oe), .mem_web(mem_web), .mem_a(mem_a),
    .mem_di(mem_di), .mem_do(mem_do)
  );

  // SRAM model: byte writes on the access edge, reads delivered LAT cycles later.
  logic [31:0] mem [0:(1<<AW)-1];
  logic [31:0] pipe0, pipe1;
  always @(posedge clk) begin
    if (mem_cs) begin
      for (int b = 0; b < 4; b++)
        if (!mem_web[b]) mem[mem_a][8*b +: 8] <= mem_di[8*b +: 8];
      if (mem_oe) pipe0 <= mem[mem_a];
    end
    pipe1 <= pipe0;
  end
  assign mem_do = pipe1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  int          r_cyc, r_ncs;
  logic [31:0] r_rdata;
  logic        r_err, r_oe;
  logic [3:0]  r_web [2];
  logic [AW-1:0] r_a [2];
  logic [31:0] r_di [2];

  // Issue one request at a negedge in IDLE; record SRAM activity and response.
  task automatic do_req(input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd);
    r_cyc = -1; r_ncs = 0; r_rdata = 32'hx; r_err = 1'bx; r_oe = 1'b0;
    for (int i = 0; i < 2; i++) begin r_web[i] = 4'hx; r_a[i] = 'x; r_di[i] = 32'hx; end
    chk("ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    for (int n = 1; n <= 20 && r_cyc < 0; n++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (mem_cs) begin
        if (r_ncs < 2) begin
          r_web[r_ncs] = mem_web; r_a[r_ncs] = mem_a; r_di[r_ncs] = mem_di;
          if (r_ncs == 0) r_oe = mem_oe;
        end
        r_ncs++;
      end
      if (resp_valid) begin
        r_cyc = n; r_rdata = resp_rdata; r_err = resp_err;
      end
    end
    @(negedge clk);
  endtask

  logic saw_resp;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rvalid", {31'd0, resp_valid}, 32'd0);
    chk("rst_cs_oe", {30'd0, mem_cs, mem_oe}, 32'd0);
    chk("rst_web", {28'd0, mem_web}, 32'hF);
    chk("rst_a", 32'(mem_a), 32'd0);
    chk("rst_di", mem_di, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // SB byte 2 of word 0x040
    do_req(1'b1, 3'b000, 32'h0000_0102, 32'h0000_00A5);
    chk("sb_ncs", 32'(r_ncs), 32'd1);
    chk("sb_a", 32'(r_a[0]), 32'h40);
    chk("sb_web", {28'd0, r_web[0]}, 32'hB);
    chk("sb_di", r_di[0], 32'h00A5_0000);
    chk("sb_lat", 32'(r_cyc), 32'd2);
    chk("sb_err", {31'd0, r_err}, 32'd0);
    chk("sb_rdata", r_rdata, 32'd0);
    chk("sb_mem", {24'd0, mem[14'h40][23:16]}, 32'hA5);

    // Aligned SW preload
    do_req(1'b1, 3'b010, 32'h0000_0100, 32'h80FF_7F01);
    chk("sw_web", {28'd0, r_web[0]}, 32'h0);
    chk("sw_lat", 32'(r_cyc), 32'd2);
    chk("sw_mem", mem[14'h40], 32'h80FF_7F01);

    do_req(1'b0, 3'b000, 32'h0000_0103, 32'd0);
    chk("lb_rdata", r_rdata, 32'hFFFF_FF80);
    chk("lb_lat", 32'(r_cyc), 32'(2 + LAT));
    chk("lb_oe_web", {27'd0, r_oe, r_web[0]}, 32'h1F);
    do_req(1'b0, 3'b100, 32'h0000_0103, 32'd0);
    chk("lbu_rdata", r_rdata, 32'h0000_0080);
    do_req(1'b0, 3'b001, 32'h0000_0102, 32'd0);
    chk("lh_rdata", r_rdata, 32'hFFFF_80FF);
    do_req(1'b0, 3'b101, 32'h0000_0102, 32'd0);
    chk("lhu_rdata", r_rdata, 32'h0000_80FF);
    do_req(1'b0, 3'b010, 32'h0000_0100, 32'd0);
    chk("lw_rdata", r_rdata, 32'h80FF_7F01);
    chk("lw_err", {31'd0, r_err}, 32'd0);

    // LH at k=1 stays inside the word but is rejected without the split build
    do_req(1'b0, 3'b001, 32'h0000_0101, 32'd0);
`ifdef LSU_MISALIGN_SPLIT_EN
    chk("lh1_rdata", r_rdata, 32'hFFFF_FF7F);
    chk("lh1_lat", 32'(r_cyc), 32'(2 + LAT));
    chk("lh1_err", {31'd0, r_err}, 32'd0);
`else
    chk("lh1_rdata", r_rdata, 32'd0);
    chk("lh1_lat", 32'(r_cyc), 32'd1);
    chk("lh1_err", {31'd0, r_err}, 32'd1);
    chk("lh1_ncs", 32'(r_ncs), 32'd0);
`endif

    // Word-crossing SW
    do_req(1'b1, 3'b010, 32'h0000_0101, 32'hDDCC_BBAA);
`ifdef LSU_MISALIGN_SPLIT_EN
    chk("sws_ncs", 32'(r_ncs), 32'd2);
    chk("sws_web0", {28'd0, r_web[0]}, 32'h1);
    chk("sws_di0", r_di[0], 32'hCCBB_AA00);
    chk("sws_a1", 32'(r_a[1]), 32'h41);
    chk("sws_web1", {28'd0, r_web[1]}, 32'hE);
    chk("sws_di1", r_di[1], 32'h0000_00DD);
    chk("sws_lat", 32'(r_cyc), 32'd3);
    chk("sws_err", {31'd0, r_err}, 32'd0);
`else
    chk("sws_ncs", 32'(r_ncs), 32'd0);
    chk("sws_lat", 32'(r_cyc), 32'd1);
    chk("sws_err", {31'd0, r_err}, 32'd1);
    chk("sws_rdata", r_rdata, 32'd0);
`endif

    // LW crossing the top of the SRAM wraps to word 0
    do_req(1'b1, 3'b010, 32'h0000_FFFC, 32'h4433_2211);
    do_req(1'b1, 3'b010, 32'h0000_0000, 32'h8877_6655);
    do_req(1'b0, 3'b010, 32'h0000_FFFF, 32'd0);
`ifdef LSU_MISALIGN_SPLIT_EN
    chk("lws_a0", 32'(r_a[0]), 32'h3FFF);
    chk("lws_a1", 32'(r_a[1]), 32'h0);
    chk("lws_rdata", r_rdata, 32'h7766_5544);
    chk("lws_lat", 32'(r_cyc), 32'(3 + 2 * LAT));
`else
    chk("lws_ncs", 32'(r_ncs), 32'd0);
    chk("lws_err", {31'd0, r_err}, 32'd1);
    chk("lws_lat", 32'(r_cyc), 32'd1);
`endif

    // Illegal funct3
    do_req(1'b1, 3'b011, 32'h0000_0100, 32'h1234_5678);
    chk("bad_st_err", {31'd0, r_err}, 32'd1);
    chk("bad_st_ncs", 32'(r_ncs), 32'd0);
    chk("bad_st_lat", 32'(r_cyc), 32'd1);
    do_req(1'b0, 3'b110, 32'h0000_0100, 32'd0);
    chk("bad_ld_err", {31'd0, r_err}, 32'd1);
    chk("bad_ld_rdata", r_rdata, 32'd0);

    // Reset during WAIT0 of a load
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("abort_wait_oe", {31'd0, mem_oe}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ready", {31'd0, req_ready}, 32'd1);
    chk("abort_oe", {31'd0, mem_oe}, 32'd0);
    chk("abort_web", {28'd0, mem_web}, 32'hF);
    saw_resp = resp_valid;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      saw_resp = saw_resp | resp_valid;
    end
    chk("abort_noresp", {31'd0, saw_resp}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
